alu_result_stage: RTL

- Downstream stage of the ALU.
- Consumes the registered ALU result, OF, Cout and HCout.
- Applies 6502 decimal (BCD) correction when required, presents the final byte over a valid/ready handshake, and maintains the processor status register P (N V 1 B D I Z C).
- Sits between the ALU output register and the accumulator/bus writeback.

---
 rtl/alu_result_if.sv | 33 +++
 rtl/alu_result_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_result_if.sv
// Handshake/result bundle between the ALU output register, alu_result_stage and
// the writeback consumer. master = ALU/consumer side, slave = alu_result_stage.
interface alu_result_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_result;
  logic       alu_of;
  logic       alu_cout;
  logic       alu_hcout;
  logic       bcd_mode;
  logic       sub_op;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       p_wr;
  logic [7:0] p_din;
  logic [7:0] p_reg;

  modport master (
    output in_valid, alu_result, alu_of, alu_cout, alu_hcout, bcd_mode, sub_op,
           upd_nz, upd_c, upd_v, out_ready, p_wr, p_din,
    input  in_ready, out_valid, out_data, p_reg
  );

  modport slave (
    input  in_valid, alu_result, alu_of, alu_cout, alu_hcout, bcd_mode, sub_op,
           upd_nz, upd_c, upd_v, out_ready, p_wr, p_din,
    output in_ready, out_valid, out_data, p_reg
  );
endinterface

// File: rtl/alu_result_stage.sv
// 6502 ALU result stage: decimal correction, valid/ready output and status register P.
// Optional macro NMOS_BCD_FLAGS_EN: in BCD mode N/Z follow the raw binary result.
module alu_result_stage #(
  parameter logic [7:0] P_RESET = 8'h24
) (
  input  logic          clk,
  input  logic          rst,
  alu_result_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ADJ_LO, ADJ_HI, HOLD} state_t;

  state_t     state_q, state_d;
  logic [7:0] raw_q, raw_d;
  logic       of_q, of_d;
  logic       cout_q, cout_d;
  logic       hc_q, hc_d;
  logic       bcd_q, bcd_d;
  logic       sub_q, sub_d;
  logic       upd_nz_q, upd_nz_d;
  logic       upd_c_q, upd_c_d;
  logic       upd_v_q, upd_v_d;
  logic [7:0] tmp_q, tmp_d;
  logic       cbcd_q, cbcd_d;
  logic [7:0] out_q, out_d;
  logic [7:0] p_q, p_d;
  logic [7:0] nz_src;

  // Low-nibble correction; returns {corrected carry, intermediate byte}.
  function automatic logic [8:0] adj_lo(input logic [7:0] raw, input logic hc,
                                        input logic cout, input logic sub);
    logic [7:0] tmp;
    logic       c;
    if (sub) begin
      tmp = hc ? raw : raw - 8'h06;
      c   = cout;
    end else begin
      tmp = (hc || (raw[3:0] > 4'd9)) ? raw + 8'h06 : raw;
      c   = cout | (raw > 8'h99);
    end
    return {c, tmp};
  endfunction

  function automatic logic [7:0] adj_hi(input logic [7:0] tmp, input logic c,
                                        input logic cout, input logic sub);
    if (sub) return cout ? tmp : tmp - 8'h60;
    else     return c ? tmp + 8'h60 : tmp;
  endfunction

  always_comb begin
    state_d  = state_q;
    raw_d    = raw_q;
    of_d     = of_q;
    cout_d   = cout_q;
    hc_d     = hc_q;
    bcd_d    = bcd_q;
    sub_d    = sub_q;
    upd_nz_d = upd_nz_q;
    upd_c_d  = upd_c_q;
    upd_v_d  = upd_v_q;
    tmp_d    = tmp_q;
    cbcd_d   = cbcd_q;
    out_d    = out_q;
    p_d      = p_q;
`ifdef NMOS_BCD_FLAGS_EN
    nz_src   = bcd_q ? raw_q : out_q;
`else
    nz_src   = out_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          raw_d    = bus.alu_result;
          of_d     = bus.alu_of;
          cout_d   = bus.alu_cout;
          hc_d     = bus.alu_hcout;
          bcd_d    = bus.bcd_mode;
          sub_d    = bus.sub_op;
          upd_nz_d = bus.upd_nz;
          upd_c_d  = bus.upd_c;
          upd_v_d  = bus.upd_v;
          if (bus.bcd_mode) begin
            state_d = ADJ_LO;
          end else begin
            out_d   = bus.alu_result;
            state_d = HOLD;
          end
        end
      end
      ADJ_LO: begin
        {cbcd_d, tmp_d} = adj_lo(raw_q, hc_q, cout_q, sub_q);
        state_d = ADJ_HI;
      end
      ADJ_HI: begin
        out_d   = adj_hi(tmp_q, cbcd_q, cout_q, sub_q);
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          if (upd_nz_q) begin
            p_d[7] = nz_src[7];
            p_d[1] = (nz_src == 8'h00);
          end
          if (upd_c_q) p_d[0] = bcd_q ? cbcd_q : cout_q;
          if (upd_v_q) p_d[6] = of_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A direct load overrides any flag update from the same cycle.
    if (bus.p_wr) p_d = bus.p_din | 8'h30;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      raw_q    <= 8'h00;
      of_q     <= 1'b0;
      cout_q   <= 1'b0;
      hc_q     <= 1'b0;
      bcd_q    <= 1'b0;
      sub_q    <= 1'b0;
      upd_nz_q <= 1'b0;
      upd_c_q  <= 1'b0;
      upd_v_q  <= 1'b0;
      tmp_q    <= 8'h00;
      cbcd_q   <= 1'b0;
      out_q    <= 8'h00;
      p_q      <= P_RESET;
    end else begin
      state_q  <= state_d;
      raw_q    <= raw_d;
      of_q     <= of_d;
      cout_q   <= cout_d;
      hc_q     <= hc_d;
      bcd_q    <= bcd_d;
      sub_q    <= sub_d;
      upd_nz_q <= upd_nz_d;
      upd_c_q  <= upd_c_d;
      upd_v_q  <= upd_v_d;
      tmp_q    <= tmp_d;
      cbcd_q   <= cbcd_d;
      out_q    <= out_d;
      p_q      <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_q;
  assign bus.p_reg     = p_q;

endmodule
